mat_a_rd_seq: RTL and testbench

Read sequencer for the matrix-A BRAM. After the A loader reports its fill complete, it drives the BRAM read address through the N×P matrix in row-major order. It absorbs the BRAM's one-cycle registered read latency and streams each element to the downstream multiply datapath over a valid/ready handshake with full backpressure. It sits between the A loader/BRAM read port and the MAC array, and is launched by the top-level controller.

---
 rtl/mat_a_rd_seq_pkg.sv | 21 ++
 rtl/mat_a_rd_seq_if.sv | 36 +++
 rtl/mat_a_rd_fifo.sv | 48 ++++
 rtl/mat_a_rd_seq.sv | 134 +++++++++++++
 tb/tb_mat_a_rd_seq.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mat_a_rd_seq_pkg.sv
// Shared types and elaboration helpers for the matrix-A read sequencer.
package mat_a_rd_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitLoad,
    StStream,
    StDrain
  } state_e;

  // Index width for a dimension; a 1-wide field is kept even for size 1.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit base_fits(input int unsigned base, input int unsigned n,
                                   input int unsigned p, input int unsigned aw);
    return (64'(base) + 64'(n) * 64'(p)) <= (64'(1) << aw);
  endfunction

endpackage

// File: rtl/mat_a_rd_seq_if.sv
// Bundle of loader, BRAM read port and element stream signals around the sequencer.
interface mat_a_rd_seq_if
  import mat_a_rd_seq_pkg::*;
#(
  parameter int unsigned N  = 2,
  parameter int unsigned P  = 4,
  parameter int unsigned AW = 8,
  parameter int unsigned DW = 32
);
  localparam int unsigned RW = idx_width(N);
  localparam int unsigned CW = idx_width(P);

  logic          wr_done;
  logic          start;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata;
  logic [DW-1:0] out_data;
  logic [RW-1:0] out_row;
  logic [CW-1:0] out_col;
  logic          out_last;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          done;

  modport master (
    output wr_done, start, mem_rdata, out_ready,
    input  mem_addr, out_data, out_row, out_col, out_last, out_valid, busy, done
  );

  modport slave (
    input  wr_done, start, mem_rdata, out_ready,
    output mem_addr, out_data, out_row, out_col, out_last, out_valid, busy, done
  );

endinterface

// File: rtl/mat_a_rd_fifo.sv
// Two-entry first-word-fall-through FIFO holding element data plus row/col/last tags.
module mat_a_rd_fifo #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_push,
  input  logic [W-1:0] i_wdata,
  input  logic         i_pop,
  output logic [W-1:0] o_rdata,
  output logic         o_valid,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         w_pop;
  logic         w_push;

  assign w_pop   = i_pop & (r_count != 2'd0);
  // A full FIFO still accepts a push in the same cycle as a pop.
  assign w_push  = i_push & ((r_count != 2'd2) | w_pop);
  assign o_rdata = r_mem[r_rd_ptr];
  assign o_valid = (r_count != 2'd0);
  assign o_count = r_count;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

// File: rtl/mat_a_rd_seq.sv
// Walks matrix A in row-major order out of the BRAM and streams tagged elements
// to the MAC array, hiding the one-cycle read latency behind a 2-entry FIFO.
module mat_a_rd_seq
  import mat_a_rd_seq_pkg::*;
#(
  parameter int unsigned N    = 2,
  parameter int unsigned P    = 4,
  parameter int unsigned AW   = 8,
  parameter int unsigned DW   = 32,
  parameter int unsigned BASE = 0
) (
  input logic            i_clk,
  input logic            i_reset,
  mat_a_rd_seq_if.slave  bus
);

  localparam int unsigned   RW       = idx_width(N);
  localparam int unsigned   CW       = idx_width(P);
  localparam int unsigned   FW       = DW + RW + CW + 1;
  localparam logic [AW-1:0] BaseAddr = AW'(BASE);
  localparam logic [RW-1:0] LastRow  = RW'(N - 1);
  localparam logic [CW-1:0] LastCol  = CW'(P - 1);

  if (!base_fits(BASE, N, P, AW)) begin : g_base_range
    $error("mat_a_rd_seq: BASE + N*P exceeds the BRAM address space");
  end

  state_e        r_state;
  state_e        w_state_next;
  logic [AW-1:0] r_addr;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_lat_valid;
  logic [RW-1:0] r_lat_row;
  logic [CW-1:0] r_lat_col;
  logic          r_lat_last;
  logic          r_done;

  logic          w_issue;
  logic          w_issue_last;
  logic          w_pop;
  logic          w_final;
  logic [2:0]    w_credit;
  logic [1:0]    w_fifo_count;
  logic          w_fifo_valid;
  logic [FW-1:0] w_fifo_wdata;
  logic [FW-1:0] w_fifo_rdata;

  assign w_pop        = w_fifo_valid & bus.out_ready;
  assign w_issue_last = (r_row == LastRow) && (r_col == LastCol);
  // Reads in flight plus buffered elements, net of this cycle's pop.
  assign w_credit     = 3'(r_lat_valid) + 3'(w_fifo_count) - 3'(w_pop);
  assign w_issue      = (r_state == StStream) && (w_credit < 3'd2);
  assign w_final      = (r_state == StDrain) && w_pop && bus.out_last;
  assign w_fifo_wdata = {bus.mem_rdata, r_lat_row, r_lat_col, r_lat_last};

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (bus.start) begin
          w_state_next = bus.wr_done ? StStream : StWaitLoad;
        end
      end
      StWaitLoad: if (bus.wr_done) w_state_next = StStream;
      StStream:   if (w_issue && w_issue_last) w_state_next = StDrain;
      StDrain:    if (w_final) w_state_next = StIdle;
      default:    w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_addr      <= BaseAddr;
      r_row       <= '0;
      r_col       <= '0;
      r_lat_valid <= 1'b0;
      r_lat_row   <= '0;
      r_lat_col   <= '0;
      r_lat_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done      <= w_final;
      r_lat_valid <= w_issue;
      if (w_issue) begin
        r_lat_row  <= r_row;
        r_lat_col  <= r_col;
        r_lat_last <= w_issue_last;
        // After the final read the walk rewinds so the next launch starts at BASE.
        if (w_issue_last) begin
          r_addr <= BaseAddr;
          r_row  <= '0;
          r_col  <= '0;
        end else begin
          r_addr <= r_addr + AW'(1);
          if (r_col == LastCol) begin
            r_col <= '0;
            r_row <= r_row + RW'(1);
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
      end
    end
  end

  mat_a_rd_fifo #(
    .W(FW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (r_lat_valid),
    .i_wdata (w_fifo_wdata),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_valid (w_fifo_valid),
    .o_count (w_fifo_count)
  );

  assign {bus.out_data, bus.out_row, bus.out_col, bus.out_last} = w_fifo_rdata;
  assign bus.out_valid = w_fifo_valid;
  assign bus.mem_addr  = r_addr;
  assign bus.busy      = (r_state != StIdle);
  assign bus.done      = r_done;

endmodule

// File: tb/tb_mat_a_rd_seq.sv
// Randomized scenario bench for mat_a_rd_seq: two instances (BASE=0 and BASE=0x10)
// checked against a row-major element model built from the BRAM contents.
module tb_mat_a_rd_seq;
  import mat_a_rd_seq_pkg::*;

  localparam int unsigned N     = 2;
  localparam int unsigned P     = 4;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 32;
  localparam int unsigned NP    = N * P;
  localparam int unsigned RW    = idx_width(N);
  localparam int unsigned CW    = idx_width(P);
  localparam int unsigned EW    = DW + RW + CW + 1;
  localparam int unsigned Base1 = 16;

  logic clk;
  logic reset;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [DW-1:0] bram0 [2**AW];
  logic [DW-1:0] bram1 [2**AW];

  mat_a_rd_seq_if #(.N(N), .P(P), .AW(AW), .DW(DW)) bus0 ();
  mat_a_rd_seq_if #(.N(N), .P(P), .AW(AW), .DW(DW)) bus1 ();

  mat_a_rd_seq #(.N(N), .P(P), .AW(AW), .DW(DW), .BASE(0)) dut0 (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus0)
  );

  mat_a_rd_seq #(.N(N), .P(P), .AW(AW), .DW(DW), .BASE(Base1)) dut1 (
    .i_clk   (clk),
    .i_reset (reset),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read BRAM models.
  always @(posedge clk) bus0.mem_rdata <= bram0[bus0.mem_addr];
  always @(posedge clk) bus1.mem_rdata <= bram1[bus1.mem_addr];

  // Reference element k of a row-major walk starting at base.
  function automatic logic [EW-1:0] exp_elem(input int bank, input int k);
    logic [DW-1:0] d;
    d = (bank == 0) ? bram0[k] : bram1[Base1 + k];
    return {d, RW'(k / P), CW'(k % P), (k == NP - 1)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [EW+2:0] got0;
    logic [EW+2:0] got1;
    bus0.out_ready = 1'b1;
    bus0.wr_done   = 1'b1;
    do_reset();
    got0 = {bus0.out_valid, bus0.out_data, bus0.out_row, bus0.out_col, bus0.out_last,
            bus0.busy, bus0.done};
    got1 = {bus1.out_valid, bus1.out_data, bus1.out_row, bus1.out_col, bus1.out_last,
            bus1.busy, bus1.done};
    n_cmp++;
    if (bus0.mem_addr !== AW'(0)) begin
      n_err++;
      $display("FAIL reset_addr0: got %h want %h", bus0.mem_addr, AW'(0));
    end
    n_cmp++;
    if (bus1.mem_addr !== AW'(Base1)) begin
      n_err++;
      $display("FAIL reset_addr1: got %h want %h", bus1.mem_addr, AW'(Base1));
    end
    n_cmp++;
    if (got0 !== '0) begin
      n_err++;
      $display("FAIL reset_outs0: got %h want 0", got0);
    end
    n_cmp++;
    if (got1 !== '0) begin
      n_err++;
      $display("FAIL reset_outs1: got %h want 0", got1);
    end
  endtask

  task automatic test_basic();
    logic [EW-1:0] got;
    do_reset();
    bus0.out_ready = 1'b1;
    bus0.wr_done   = 1'b1;
    bus0.start     = 1'b1;
    tick();
    bus0.start = 1'b0;
    n_cmp++;
    if ({bus0.mem_addr, bus0.busy, bus0.out_valid} !== {AW'(0), 1'b1, 1'b0}) begin
      n_err++;
      $display("FAIL basic_t1: got addr=%h busy=%b valid=%b want addr=0 busy=1 valid=0",
               bus0.mem_addr, bus0.busy, bus0.out_valid);
    end
    tick();
    n_cmp++;
    if (bus0.out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL basic_t2_valid: got %b want 0", bus0.out_valid);
    end
    tick();
    for (int k = 0; k < NP; k++) begin
      got = {bus0.out_data, bus0.out_row, bus0.out_col, bus0.out_last};
      n_cmp++;
      if (bus0.out_valid !== 1'b1 || got !== exp_elem(0, k)) begin
        n_err++;
        $display("FAIL basic_elem%0d: got valid=%b %h want valid=1 %h", k, bus0.out_valid,
                 got, exp_elem(0, k));
      end
      tick();
    end
    n_cmp++;
    if ({bus0.done, bus0.busy, bus0.out_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL basic_done: got done,busy,valid=%b want 100",
               {bus0.done, bus0.busy, bus0.out_valid});
    end
    tick();
    n_cmp++;
    if (bus0.done !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done_pulse: got %b want 0", bus0.done);
    end
  endtask

  task automatic test_wait_load();
    logic [EW-1:0] got;
    do_reset();
    bus0.out_ready = 1'b1;
    bus0.wr_done   = 1'b0;
    bus0.start     = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      bus0.start = (i == 2);
      n_cmp++;
      if ({bus0.mem_addr, bus0.busy, bus0.out_valid} !== {AW'(0), 1'b1, 1'b0}) begin
        n_err++;
        $display("FAIL wait_hold%0d: got addr=%h busy=%b valid=%b want addr=0 busy=1 valid=0",
                 i, bus0.mem_addr, bus0.busy, bus0.out_valid);
      end
      tick();
    end
    bus0.start   = 1'b0;
    bus0.wr_done = 1'b1;
    tick();
    for (int i = 1; i < 3; i++) begin
      n_cmp++;
      if ({bus0.out_valid, bus0.busy} !== 2'b01) begin
        n_err++;
        $display("FAIL wait_early%0d: got valid,busy=%b want 01", i,
                 {bus0.out_valid, bus0.busy});
      end
      tick();
    end
    for (int k = 0; k < NP; k++) begin
      got = {bus0.out_data, bus0.out_row, bus0.out_col, bus0.out_last};
      n_cmp++;
      if (bus0.out_valid !== 1'b1 || bus0.busy !== 1'b1 || got !== exp_elem(0, k)) begin
        n_err++;
        $display("FAIL wait_elem%0d: got valid=%b busy=%b %h want valid=1 busy=1 %h", k,
                 bus0.out_valid, bus0.busy, got, exp_elem(0, k));
      end
      tick();
    end
    n_cmp++;
    if ({bus0.done, bus0.busy} !== 2'b10) begin
      n_err++;
      $display("FAIL wait_done: got done,busy=%b want 10", {bus0.done, bus0.busy});
    end
  endtask

  task automatic test_random_ready();
    logic [EW-1:0] got;
    logic [EW-1:0] held;
    bit            stalled;
    int            k;
    do_reset();
    bus0.out_ready = 1'b0;
    bus0.wr_done   = 1'b1;
    bus0.start     = 1'b1;
    tick();
    bus0.start = 1'b0;
    repeat (8) tick();
    // Fully stalled: only the two buffered reads may have been issued.
    got = {bus0.out_data, bus0.out_row, bus0.out_col, bus0.out_last};
    n_cmp++;
    if (bus0.mem_addr !== AW'(2) || bus0.out_valid !== 1'b1 || got !== exp_elem(0, 0)) begin
      n_err++;
      $display("FAIL stall_fill: got addr=%h valid=%b %h want addr=02 valid=1 %h",
               bus0.mem_addr, bus0.out_valid, got, exp_elem(0, 0));
    end
    bus0.out_ready = 1'b1;
    tick();
    bus0.out_ready = 1'b0;
    tick();
    n_cmp++;
    if (bus0.mem_addr !== AW'(3)) begin
      n_err++;
      $display("FAIL stall_resume: got addr=%h want 03", bus0.mem_addr);
    end
    k       = 1;
    stalled = 1'b0;
    held    = '0;
    for (int cyc = 0; cyc < 400 && k < NP; cyc++) begin
      bus0.out_ready = 1'($urandom_range(0, 1));
      if (bus0.out_valid) begin
        got = {bus0.out_data, bus0.out_row, bus0.out_col, bus0.out_last};
        if (stalled) begin
          n_cmp++;
          if (got !== held) begin
            n_err++;
            $display("FAIL rand_stable: got %h want %h", got, held);
          end
        end
        if (bus0.out_ready) begin
          n_cmp++;
          if (got !== exp_elem(0, k)) begin
            n_err++;
            $display("FAIL rand_elem%0d: got %h want %h", k, got, exp_elem(0, k));
          end
          k++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held    = got;
        end
      end
      tick();
    end
    bus0.out_ready = 1'b0;
    n_cmp++;
    if (k != NP) begin
      n_err++;
      $display("FAIL rand_count: got %0d elements want %0d", k, NP);
    end
    n_cmp++;
    if ({bus0.done, bus0.busy, bus0.out_valid} !== 3'b100) begin
      n_err++;
      $display("FAIL rand_done: got done,busy,valid=%b want 100",
               {bus0.done, bus0.busy, bus0.out_valid});
    end
  endtask

  task automatic test_reset_mid();
    logic [EW-1:0] got;
    do_reset();
    bus0.out_ready = 1'b1;
    bus0.wr_done   = 1'b1;
    bus0.start     = 1'b1;
    tick();
    bus0.start = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    got = {bus0.out_data, bus0.out_row, bus0.out_col, bus0.out_last};
    n_cmp++;
    if ({bus0.mem_addr, bus0.out_valid, got, bus0.busy, bus0.done} !== '0) begin
      n_err++;
      $display("FAIL midreset_outs: got addr=%h valid=%b %h busy=%b done=%b want all 0",
               bus0.mem_addr, bus0.out_valid, got, bus0.busy, bus0.done);
    end
    repeat (3) tick();
    n_cmp++;
    if ({bus0.out_valid, bus0.busy, bus0.done} !== 3'b000) begin
      n_err++;
      $display("FAIL midreset_quiet: got valid,busy,done=%b want 000",
               {bus0.out_valid, bus0.busy, bus0.done});
    end
    bus0.start = 1'b1;
    tick();
    bus0.start = 1'b0;
    tick();
    tick();
    for (int k = 0; k < NP; k++) begin
      got = {bus0.out_data, bus0.out_row, bus0.out_col, bus0.out_last};
      n_cmp++;
      if (bus0.out_valid !== 1'b1 || got !== exp_elem(0, k)) begin
        n_err++;
        $display("FAIL replay_elem%0d: got valid=%b %h want valid=1 %h", k, bus0.out_valid,
                 got, exp_elem(0, k));
      end
      tick();
    end
    n_cmp++;
    if (bus0.done !== 1'b1) begin
      n_err++;
      $display("FAIL replay_done: got %b want 1", bus0.done);
    end
  endtask

  task automatic test_restart_ignored();
    logic [EW-1:0] got;
    int            k;
    int            dones;
    do_reset();
    bus0.out_ready = 1'b1;
    bus0.wr_done   = 1'b1;
    bus0.start     = 1'b1;
    tick();
    bus0.start = 1'b0;
    k     = 0;
    dones = 0;
    for (int cyc = 0; cyc < NP + 6; cyc++) begin
      bus0.start = (k == 2);
      if (k == 4) bus0.wr_done = 1'b0;
      if (bus0.done === 1'b1) dones++;
      if (bus0.out_valid === 1'b1) begin
        got = {bus0.out_data, bus0.out_row, bus0.out_col, bus0.out_last};
        n_cmp++;
        if (k >= NP || got !== exp_elem(0, k)) begin
          n_err++;
          $display("FAIL restart_elem%0d: got %h want %h", k, got, exp_elem(0, k % NP));
        end
        k++;
      end
      tick();
    end
    bus0.start   = 1'b0;
    bus0.wr_done = 1'b1;
    n_cmp++;
    if (k != NP || dones != 1 || bus0.busy !== 1'b0) begin
      n_err++;
      $display("FAIL restart_summary: got elems=%0d dones=%0d busy=%b want %0d 1 0", k, dones,
               bus0.busy, NP);
    end
  endtask

  task automatic test_base_offset();
    logic [EW-1:0] got;
    do_reset();
    bus1.out_ready = 1'b1;
    bus1.wr_done   = 1'b1;
    bus1.start     = 1'b1;
    tick();
    bus1.start = 1'b0;
    for (int c = 0; c < NP + 2; c++) begin
      if (c < NP) begin
        n_cmp++;
        if (bus1.mem_addr !== AW'(Base1 + c)) begin
          n_err++;
          $display("FAIL base_addr%0d: got %h want %h", c, bus1.mem_addr, AW'(Base1 + c));
        end
      end
      if (c >= 2) begin
        got = {bus1.out_data, bus1.out_row, bus1.out_col, bus1.out_last};
        n_cmp++;
        if (bus1.out_valid !== 1'b1 || got !== exp_elem(1, c - 2)) begin
          n_err++;
          $display("FAIL base_elem%0d: got valid=%b %h want valid=1 %h", c - 2,
                   bus1.out_valid, got, exp_elem(1, c - 2));
        end
      end
      tick();
    end
    repeat (NP - 2) tick();
    n_cmp++;
    if ({bus1.done, bus1.busy} !== 2'b00) begin
      n_err++;
      $display("FAIL base_idle: got done,busy=%b want 00", {bus1.done, bus1.busy});
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus0.start     = 1'b0;
    bus0.wr_done   = 1'b0;
    bus0.out_ready = 1'b0;
    bus1.start     = 1'b0;
    bus1.wr_done   = 1'b0;
    bus1.out_ready = 1'b0;
    for (int a = 0; a < 2**AW; a++) begin
      bram0[a] = DW'(a);
      bram1[a] = $urandom;
    end
    tick();
    test_reset();
    test_basic();
    test_wait_load();
    test_random_ready();
    test_reset_mid();
    test_restart_ignored();
    test_base_offset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
